// File: rtl/regs_dump_reader_if.sv
// Bundle of the dump reader's start request, register-file read port
// and beat stream. The master side is the dump reader itself; the
// slave side is whoever requests dumps, serves reads and consumes beats.
interface regs_dump_reader_if;
   logic        start;
   logic [4:0]  firstReg;
   logic [4:0]  lastReg;
   logic [4:0]  regNum;
   logic [31:0] regReadData;
   logic        dumpValid;
   logic        dumpReady;
   logic [4:0]  dumpNum;
   logic [31:0] dumpData;
   logic        busy;
   logic        done;

   modport master (
      input  start,
      input  firstReg,
      input  lastReg,
      output regNum,
      input  regReadData,
      output dumpValid,
      input  dumpReady,
      output dumpNum,
      output dumpData,
      output busy,
      output done
   );

   modport slave (
      output start,
      output firstReg,
      output lastReg,
      input  regNum,
      output regReadData,
      input  dumpValid,
      output dumpReady,
      input  dumpNum,
      input  dumpData,
      input  busy,
      input  done
   );
endinterface

// File: rtl/regs_dump_reader.sv
// Read-only debug client of the register file. A start request latches
// an inclusive register range, then each register is read through one
// combinational read port and streamed out as a {number, data} beat on
// a valid/ready handshake. A one-cycle done pulse closes the range.
module regs_dump_reader #(
   parameter bit SKIP_X0 = 1'b0,
   parameter int MAX_REG = 31
) (
   input logic                clk,
   input logic                reset,
   regs_dump_reader_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      HOLD,
      FIN
   } stateType;

   localparam logic [4:0] MaxReg = 5'(MAX_REG);

   stateType   state;
   logic [4:0] cur;
   logic [4:0] last;
   logic [4:0] clampedLast;
   logic       skipCur;

   // Upper bound of the requested range, clamped to the highest legal index
   // so an oversize request simply stops at the top of the register file.
   always_comb begin
      clampedLast = bus.lastReg;
      if (bus.lastReg > MaxReg) begin
         clampedLast = MaxReg;
      end
   end

   // x0 is optionally suppressed; it never produces a beat when enabled.
   always_comb begin
      skipCur = SKIP_X0 && (cur == 5'd0);
   end

   // The read address only points at a real register while a capture is
   // pending, so the shared read port sees address 0 at all other times.
   always_comb begin
      bus.regNum = 5'd0;
      if (state == READ) begin
         bus.regNum = cur;
      end
   end

   // Status flags decode straight from the state register.
   always_comb begin
      bus.busy = (state != IDLE);
      bus.done = (state == FIN);
   end

   // Main walk: latch the range, capture one register per READ cycle, hold
   // the beat until the consumer takes it, and test for the end of range
   // before incrementing so a range ending at the top never wraps to x0.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cur           <= 5'd0;
         last          <= 5'd0;
         bus.dumpValid <= 1'b0;
         bus.dumpNum   <= 5'd0;
         bus.dumpData  <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  cur  <= bus.firstReg;
                  last <= clampedLast;
                  if (bus.firstReg > clampedLast) begin
                     state <= FIN;
                  end else begin
                     state <= READ;
                  end
               end
            end
            READ: begin
               if (skipCur) begin
                  if (cur == last) begin
                     state <= FIN;
                  end else begin
                     cur <= cur + 5'd1;
                  end
               end else begin
                  bus.dumpData  <= bus.regReadData;
                  bus.dumpNum   <= cur;
                  bus.dumpValid <= 1'b1;
                  state         <= HOLD;
               end
            end
            HOLD: begin
               if (bus.dumpReady) begin
                  bus.dumpValid <= 1'b0;
                  if (cur == last) begin
                     state <= FIN;
                  end else begin
                     cur   <= cur + 5'd1;
                     state <= READ;
                  end
               end
            end
            FIN: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regs_dump_reader.sv
// Randomized self-checking bench for regs_dump_reader. Two instances share
// one behavioural register file: one emits x0, the other skips it.
module tb_regs_dump_reader;

   logic clk = 1'b0;
   logic reset = 1'b1;

   // Free-running clock.
   always #5 clk = ~clk;

   regs_dump_reader_if ifA ();
   regs_dump_reader_if ifB ();

   regs_dump_reader #(.SKIP_X0(1'b0), .MAX_REG(31)) dutA (
      .clk   (clk),
      .reset (reset),
      .bus   (ifA)
   );

   regs_dump_reader #(.SKIP_X0(1'b1), .MAX_REG(31)) dutB (
      .clk   (clk),
      .reset (reset),
      .bus   (ifB)
   );

   logic [31:0] regs [32];
   int checks = 0;
   int failures = 0;

   // Register file read ports: combinational, x0 always reads as zero.
   assign ifA.regReadData = (ifA.regNum == 5'd0) ? 32'd0 : regs[ifA.regNum];
   assign ifB.regReadData = (ifB.regNum == 5'd0) ? 32'd0 : regs[ifB.regNum];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int sel, input logic st, input logic [4:0] f, input logic [4:0] l, input logic rdy);
      if (sel == 0) begin
         ifA.start = st; ifA.firstReg = f; ifA.lastReg = l; ifA.dumpReady = rdy;
      end else begin
         ifB.start = st; ifB.firstReg = f; ifB.lastReg = l; ifB.dumpReady = rdy;
      end
   endtask

   task automatic sampleOutputs(input int sel, output logic v, output logic [4:0] n,
                                output logic [31:0] d, output logic dn, output logic b);
      if (sel == 0) begin
         v = ifA.dumpValid; n = ifA.dumpNum; d = ifA.dumpData; dn = ifA.done; b = ifA.busy;
      end else begin
         v = ifB.dumpValid; n = ifB.dumpNum; d = ifB.dumpData; dn = ifB.done; b = ifB.busy;
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // One complete dump on the selected instance. mode 0: always ready,
   // mode 1: ready pattern 0,0,1 per beat, mode 2: random ready.
   // With glitch set, a stray start with a random range is raised while
   // the first beat is stalled.
   task automatic runDump(input int sel, input int f, input int l, input int mode, input bit glitch);
      int          expNum[$];
      logic [31:0] expData[$];
      bit          skip;
      int          lastL, beats, expLatency, noBeatDone;
      int          edges, firstSeen, lastBeatStart, lastXferEdge, phase;
      logic [4:0]  lastXferNum;
      logic [31:0] lastXferData;
      logic        v, dn, b, rdy, prevValid, prevReady, st;
      logic [4:0]  n, prevNum, gf, gl;
      logic [31:0] d, prevData;
      bit          glitched, sawDone;

      skip  = (sel == 1);
      lastL = (l > 31) ? 31 : l;
      for (int i = f; i <= lastL; i++) begin
         if (!(skip && i == 0)) begin
            expNum.push_back(i);
            expData.push_back((i == 0) ? 32'd0 : regs[i]);
         end
      end
      beats      = expNum.size();
      expLatency = (skip && f == 0) ? 3 : 2;
      noBeatDone = (f > lastL) ? 1 : 2;

      applyStimulus(sel, 1'b1, 5'(f), 5'(l), 1'b0);
      stepCycle();
      edges = 1;
      firstSeen = -1; lastBeatStart = -1; lastXferEdge = -1; phase = 0;
      lastXferNum = '0; lastXferData = '0;
      prevValid = 1'b0; prevReady = 1'b0; prevNum = '0; prevData = '0;
      glitched = 1'b0; sawDone = 1'b0;

      while (edges < 400) begin
         sampleOutputs(sel, v, n, d, dn, b);
         if (dn) begin
            sawDone = 1'b1;
            break;
         end
         checkOutput("busyDuringDump", b, 1'b1);
         if (prevValid && !prevReady) begin
            checkOutput("holdValid", v, 1'b1);
            checkOutput("holdNum", n, prevNum);
            checkOutput("holdData", d, prevData);
         end else if (v) begin
            if (firstSeen < 0) begin
               firstSeen = edges;
               checkOutput("firstLatency", edges, expLatency);
            end else if (mode == 0) begin
               checkOutput("beatGap", edges - lastBeatStart, 2);
            end
            lastBeatStart = edges;
            phase = 0;
         end
         st = 1'b0; gf = 5'(f); gl = 5'(l);
         if (v) begin
            case (mode)
               0:       rdy = 1'b1;
               1:       rdy = (phase % 3 == 2);
               default: rdy = 1'($urandom_range(0, 1));
            endcase
            phase++;
            if (glitch && !glitched) begin
               glitched = 1'b1;
               rdy = 1'b0;
               st  = 1'b1;
               gf  = 5'($urandom_range(0, 31));
               gl  = 5'($urandom_range(0, 31));
            end
            if (rdy) begin
               if (expNum.size() == 0) begin
                  checkOutput("extraBeat", n, 5'h1f + 5'h1);
               end else begin
                  checkOutput("beatNum", n, expNum.pop_front());
                  checkOutput("beatData", d, expData.pop_front());
               end
               lastXferEdge = edges;
               lastXferNum  = n;
               lastXferData = d;
            end
         end else begin
            rdy = 1'($urandom_range(0, 1));
         end
         applyStimulus(sel, st, gf, gl, rdy);
         prevValid = v; prevReady = rdy; prevNum = n; prevData = d;
         stepCycle();
         edges++;
      end

      applyStimulus(sel, 1'b0, 5'(f), 5'(l), 1'b0);
      checkOutput("doneSeen", sawDone, 1'b1);
      if (sawDone) begin
         checkOutput("doneEdge", edges, (beats > 0) ? lastXferEdge + 1 : noBeatDone);
         checkOutput("missingBeats", expNum.size(), 0);
         checkOutput("validAtDone", v, 1'b0);
         checkOutput("busyAtDone", b, 1'b1);
         if (beats > 0) begin
            checkOutput("numKeptAtDone", n, lastXferNum);
            checkOutput("dataKeptAtDone", d, lastXferData);
         end
         stepCycle();
         sampleOutputs(sel, v, n, d, dn, b);
         checkOutput("donePulseWidth", dn, 1'b0);
         checkOutput("busyAfterDone", b, 1'b0);
      end
   endtask

   // Directed sequences first, then randomized ranges with live register writes.
   initial begin
      logic        v, dn, b;
      logic [4:0]  n;
      logic [31:0] d;
      int          waitCount;

      regs[0] = 32'd0;
      for (int i = 1; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i);
      applyStimulus(0, 1'b0, 5'd0, 5'd0, 1'b0);
      applyStimulus(1, 1'b0, 5'd0, 5'd0, 1'b0);
      reset = 1'b1;
      stepCycle();
      stepCycle();
      checkOutput("resetValid", ifA.dumpValid, 1'b0);
      checkOutput("resetBusy", ifA.busy, 1'b0);
      checkOutput("resetDone", ifA.done, 1'b0);
      checkOutput("resetRegNum", ifA.regNum, 5'd0);
      checkOutput("resetDumpNum", ifA.dumpNum, 5'd0);
      checkOutput("resetDumpData", ifA.dumpData, 32'd0);
      checkOutput("resetBusyB", ifB.busy, 1'b0);
      reset = 1'b0;
      stepCycle();

      runDump(0, 0, 31, 0, 1'b0);
      runDump(0, 5, 7, 1, 1'b0);
      runDump(1, 0, 2, 0, 1'b0);
      runDump(1, 0, 0, 0, 1'b0);
      runDump(0, 9, 3, 0, 1'b0);
      runDump(0, 31, 31, 0, 1'b0);
      runDump(1, 31, 31, 2, 1'b0);
      runDump(0, 10, 12, 2, 1'b1);

      // Reset in the middle of a held beat drops it and returns to idle.
      applyStimulus(0, 1'b1, 5'd3, 5'd8, 1'b0);
      stepCycle();
      applyStimulus(0, 1'b0, 5'd3, 5'd8, 1'b0);
      waitCount = 0;
      while (!ifA.dumpValid && waitCount < 10) begin
         stepCycle();
         waitCount++;
      end
      checkOutput("validBeforeReset", ifA.dumpValid, 1'b1);
      reset = 1'b1;
      stepCycle();
      checkOutput("midResetValid", ifA.dumpValid, 1'b0);
      checkOutput("midResetBusy", ifA.busy, 1'b0);
      checkOutput("midResetDone", ifA.done, 1'b0);
      checkOutput("midResetRegNum", ifA.regNum, 5'd0);
      checkOutput("midResetDumpNum", ifA.dumpNum, 5'd0);
      checkOutput("midResetDumpData", ifA.dumpData, 32'd0);
      reset = 1'b0;
      stepCycle();
      runDump(0, 3, 8, 2, 1'b0);

      // A write on the falling edge just before the capture is visible in the beat.
      regs[4] = 32'h1000_0004;
      applyStimulus(0, 1'b1, 5'd4, 5'd4, 1'b0);
      stepCycle();
      applyStimulus(0, 1'b0, 5'd4, 5'd4, 1'b1);
      @(negedge clk);
      regs[4] = 32'hDEAD_BEEF;
      stepCycle();
      sampleOutputs(0, v, n, d, dn, b);
      checkOutput("lateWriteValid", v, 1'b1);
      checkOutput("lateWriteNum", n, 5'd4);
      checkOutput("lateWriteData", d, 32'hDEAD_BEEF);
      stepCycle();
      sampleOutputs(0, v, n, d, dn, b);
      checkOutput("lateWriteDone", dn, 1'b1);
      applyStimulus(0, 1'b0, 5'd4, 5'd4, 1'b0);
      stepCycle();

      for (int t = 0; t < 30; t++) begin
         int sel, f, l;
         for (int w = 0; w < 3; w++) regs[$urandom_range(1, 31)] = $urandom;
         sel = $urandom_range(0, 1);
         f   = $urandom_range(0, 31);
         l   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(f, (f + 6 > 31) ? 31 : f + 6);
         runDump(sel, f, l, 2, 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regs_dump_reader.md
Name: regs_dump_reader

Overview:
Debug/verification read-side client of the CPU register file. On a start request it walks a contiguous range of architectural registers through one combinational read port. Each value is streamed out as a {register number, data} beat over a valid/ready handshake, and a one-cycle done pulse marks the end of the range. It sits beside the register file, shares a read port with the test/debug path, and never writes registers.

Parameters:
SKIP_X0, 0, when 1 register x0 is never emitted as a beat, even if it lies inside the range
MAX_REG, 31, highest legal register index; lastReg values above it are clamped to MAX_REG

Ports:
clk  input  1  rising-edge clock for this block
reset  input  1  synchronous, active-high reset
start  input  1  dump request; sampled only in IDLE
firstReg  input  5  first register index of the range; latched on an accepted start
lastReg  input  5  last register index of the range, inclusive; latched on an accepted start
regNum  output  5  register-file read-port address
regReadData  input  32  register-file read data; combinational from regNum
dumpValid  output  1  beat valid
dumpReady  input  1  consumer ready
dumpNum  output  5  register index of the current beat
dumpData  output  32  register value of the current beat
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the range completes

Behaviour:
- Reset: all state is synchronous to the rising edge of clk.
  - On reset=1 at a clk rising edge: state=IDLE, cur=0, last=0.
  - Outputs after reset: regNum=0, dumpValid=0, dumpNum=0, dumpData=0, busy=0, done=0.
  - Reset overrides everything, including mid-dump; any pending beat is dropped.
- States: IDLE, READ, HOLD, FIN.
- IDLE:
  - regNum=0.
  - If start=1: latch cur=firstReg and last=min(lastReg, MAX_REG).
  - If firstReg > clamped last, go to FIN with no beats. Otherwise go to READ.
- READ (one cycle):
  - regNum=cur.
  - If SKIP_X0=1 and cur=0: emit no beat. If cur==last go to FIN, else cur=cur+1 and stay in READ.
  - Otherwise, at the next rising edge: dumpData<=regReadData, dumpNum<=cur, dumpValid<=1, go to HOLD.
- HOLD:
  - dumpValid, dumpNum and dumpData stay stable until the handshake.
  - A beat transfers at a rising edge with dumpValid=1 and dumpReady=1.
  - On transfer: dumpValid<=0. If cur==last go to FIN, else cur<=cur+1 and go to READ.
  - Backpressure may last any number of cycles; nothing changes while dumpReady=0.
- FIN:
  - done=1 for exactly this one cycle, then go to IDLE.
  - dumpNum/dumpData keep the last beat's values; they are not cleared.
- busy=1 in READ, HOLD and FIN.
- start is ignored when not in IDLE; it is not queued.
- Throughput: at most one beat per 2 cycles. Latency from start to the first dumpValid is 2 rising edges.
- Wrap: cur never increments past last. The cur==last check runs before any increment, so a range ending at 31 never wraps to 0.
- Coherency:
  - The register file writes on the falling edge, so a write in the negedge before a READ capture edge is visible in the beat.
  - A dump is not an atomic snapshot; later registers may reflect later writes.
- With SKIP_X0=0, x0 is emitted with data equal to regReadData, which the register file returns as 0.

Test Plan:
1. Preload x1..x31 with 0x1000_0000+i; SKIP_X0=0; start with first=0, last=31; dumpReady=1 → 32 beats with dumpNum 0..31, dumpData 0 then 0x1000_0001..0x1000_001F. First dumpValid 2 edges after start, beats every 2 cycles, done pulse one cycle after the last transfer, busy then 0.
2. Range first=5, last=7 with dumpReady toggling 0,0,1 → exactly beats 5, 6, 7. Data is held stable through stalls. No beat is duplicated or lost.
3. SKIP_X0=1, first=0, last=2 → beats for x1 and x2 only. Repeat with first=last=0 → no beats, done pulse.
4. first=9, last=3 → no dumpValid, done 1 edge after start. lastReg=31 with first=31 → a single beat for x31 and no wrap to x0.
5. Assert start again during HOLD → ignored, range unchanged. Assert reset while in HOLD with dumpValid=1 → next cycle dumpValid=0, busy=0, state IDLE. A fresh start then works normally.
6. Write x4=0xDEADBEEF on the negedge just before the READ capture of x4 → the beat for x4 carries 0xDEADBEEF.
